// File: rtl/int_sched.sv
// Interrupt scheduler: captures four request edges, picks one by fixed priority,
// and sequences vectored entry (squash + push + jump) and return-from-interrupt.
module int_sched #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] VEC_BASE   = 10'h3F0,
  parameter int              VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      irq,
  input  logic [3:0]      ie,
  input  logic            gie,
  input  logic [PC_W-1:0] pc_in,
  input  logic            reti,
  output logic            int_take,
  output logic            int_push,
  output logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] int_vec,
  output logic            int_ret,
  output logic            int_active,
  output logic [3:0]      ack,
  output logic [3:0]      pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [3:0]      pending_r, pending_nxt_s, irq_prev_r, clr_s, eligible_s;
  logic [1:0]      sel_r, sel_nxt_s;
  logic            req_s;
  logic [PC_W-1:0] vec_off_s;

  // Lowest set index wins (line 0 is highest priority).
  function automatic logic [1:0] prio_sel(input logic [3:0] m);
    logic [1:0] r;
    casez (m)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  assign eligible_s = pending_r & ie;
  assign req_s      = gie && (|eligible_s);

  // Next-state and selection latch; RETURN always falls to IDLE so one main-program cycle runs.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = ST_ENTER;
          sel_nxt_s   = prio_sel(eligible_s);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENTER:   state_nxt_s = ST_SERVICE;
      ST_SERVICE: begin
        if (reti) begin
          state_nxt_s = ST_RETURN;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      ST_RETURN:  state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Pending update: a fresh edge on the serviced line outranks its clear.
  always_comb begin
    clr_s         = (state_r == ST_ENTER) ? onehot4(sel_r) : 4'b0000;
    pending_nxt_s = (pending_r & ~clr_s) | (irq & ~irq_prev_r);
  end

  // State, selection and edge-capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      sel_r      <= 2'd0;
      pending_r  <= 4'b0000;
      irq_prev_r <= 4'b0000;
    end else begin
      state_r    <= state_nxt_s;
      sel_r      <= sel_nxt_s;
      pending_r  <= pending_nxt_s;
      irq_prev_r <= irq;
    end
  end

  assign vec_off_s = PC_W'(sel_r) * PC_W'(VEC_STRIDE);

  // Override lines decoded purely from the state register.
  always_comb begin
    int_take   = 1'b0;
    int_push   = 1'b0;
    int_ret    = 1'b0;
    int_active = 1'b0;
    ack        = 4'b0000;
    int_vec    = VEC_BASE;
    push_data  = pc_in;
    pending    = pending_r;
    case (state_r)
      ST_ENTER: begin
        int_take = 1'b1;
        int_push = 1'b1;
        ack      = onehot4(sel_r);
        int_vec  = VEC_BASE + vec_off_s;
      end
      ST_SERVICE: int_active = 1'b1;
      ST_RETURN: begin
        int_ret    = 1'b1;
        int_active = 1'b1;
      end
      ST_IDLE:    int_take = 1'b0;
      default:    int_take = 1'b0;
    endcase
  end

endmodule
